// File: rtl/divclk_pkg.sv
// Shared types and constants for the programmable clock divider.
package divclk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } state_t;

  localparam int DIV_MIN   = 2;
  localparam int W_DEFAULT = 31;

endpackage

// File: rtl/divclk_ctrl_div_counter.sv
// Period counter: counts 0..term while enabled, flags the wrap cycle.
module div_counter
  import divclk_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  assign wrap = en && (cnt == term);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr || wrap) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/divclk_ctrl.sv
// Run-time programmable clock divider with boundary-aligned ratio updates
// and graceful start/stop.
module divclk_ctrl
  import divclk_pkg::*;
#(
  parameter int          W         = W_DEFAULT,
  parameter int unsigned N_DEFAULT = 488
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic         busy,
  output logic [W-1:0] cur_div,
  output logic         tick,
  output logic         div_out
);

  state_t       state, state_next;
  logic [W-1:0] nxt_div, nxt_div_next, cur_div_next;
  logic [W-1:0] cnt, cnt_after;
  logic         pend, pend_next;
  logic         wrap, xfer, bad, good;
  logic         run_next, tick_next, div_out_next;

  assign cfg_ready = !pend;
  assign busy      = pend;
  assign xfer      = cfg_valid && !pend;
  assign bad       = xfer && (cfg_div < W'(DIV_MIN));
  assign good      = xfer && !bad;

  div_counter #(.W(W)) u_counter (
    .clk  (clk),
    .rstn (rstn),
    .clr  (state == IDLE),
    .en   (state != IDLE),
    .term (cur_div - W'(1)),
    .cnt  (cnt),
    .wrap (wrap)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Outputs are registered from the values the counter and ratio will hold
  // after this edge, so tick/div_out line up with the cycle they describe.
  always_comb begin
    state_next   = state;
    cur_div_next = cur_div;
    nxt_div_next = nxt_div;
    pend_next    = pend;
    case (state)
      IDLE:    if (en) state_next = RUN;
      RUN:     if (!en) state_next = STOP;
      STOP:    if (en) state_next = RUN;
               else if (wrap) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (wrap && pend) begin
      cur_div_next = nxt_div;
      pend_next    = 1'b0;
    end
    // A transfer landing on a wrap edge bypasses the pending register.
    if (good) begin
      if (state == IDLE || wrap) begin
        cur_div_next = cfg_div;
      end else begin
        nxt_div_next = cfg_div;
        pend_next    = 1'b1;
      end
    end
    run_next     = (state_next != IDLE);
    cnt_after    = (state == IDLE || wrap) ? '0 : cnt + W'(1);
    tick_next    = run_next && (cnt_after == '0);
    div_out_next = run_next && (cnt_after < (cur_div_next >> 1));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_div <= W'(N_DEFAULT);
      nxt_div <= '0;
      pend    <= 1'b0;
      tick    <= 1'b0;
      div_out <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cur_div <= cur_div_next;
      nxt_div <= nxt_div_next;
      pend    <= pend_next;
      tick    <= tick_next;
      div_out <= div_out_next;
      cfg_err <= bad;
    end
  end

endmodule

// File: tb/tb_divclk_ctrl.sv
// Scoreboard bench for divclk_ctrl: stimulus queues expected period ratios,
// a monitor checks every tick, period length and div_out phase against them.
module tb_divclk_ctrl;

  localparam int W = 31;

  logic         clk = 1'b0;
  logic         rstn;
  logic         en;
  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic         cfg_err;
  logic         busy;
  logic [W-1:0] cur_div;
  logic         tick;
  logic         div_out;

  int check_count = 0;
  int pass_count  = 0;

  int exp_q[$];
  int err_expected = 0;
  int err_seen     = 0;
  int act_n        = 0;
  int phase        = 0;
  bit active       = 1'b0;
  int hold;

  divclk_ctrl #(.W(W), .N_DEFAULT(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .busy      (busy),
    .cur_div   (cur_div),
    .tick      (tick),
    .div_out   (div_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    check_count++;
    if (actual == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input logic en_v, input logic valid_v, input logic [W-1:0] div_v);
    @(negedge clk);
    en        = en_v;
    cfg_valid = valid_v;
    cfg_div   = div_v;
  endtask

  task automatic idle_wait(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, '0);
  endtask

  task automatic wait_ticks(input int k);
    int seen = 0;
    int cyc  = 0;
    while (seen < k && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (tick) seen++;
    end
    checkOutput("tick_wait", seen, k);
  endtask

  // Holds the offer until cfg_ready, then drops it after the accepting edge.
  task automatic offer(input logic [W-1:0] d, output int held);
    held = 0;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_div   = d;
    while (!cfg_ready && held < 64) begin
      @(negedge clk);
      held++;
    end
    if (held >= 64) checkOutput("offer_timeout", held, 0);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_tick"}, tick, 0);
    checkOutput({tag, "_div_out"}, div_out, 0);
    checkOutput({tag, "_cfg_err"}, cfg_err, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_cfg_ready"}, cfg_ready, 1);
    checkOutput({tag, "_cur_div"}, cur_div, 4);
  endtask

  // Monitor: every tick must start the next queued period at the queued ratio.
  always @(negedge clk) begin
    if (!rstn) begin
      active = 1'b0;
    end else begin
      if (tick) begin
        if (active) checkOutput("period_len", phase, act_n);
        checkOutput("tick_expected", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          act_n  = exp_q.pop_front();
          phase  = 0;
          active = 1'b1;
          checkOutput("tick_cur_div", cur_div, act_n);
        end else begin
          active = 1'b0;
        end
      end
      if (active && phase < act_n) begin
        checkOutput("div_out", div_out, (phase < act_n / 2) ? 1 : 0);
      end else begin
        active = 1'b0;
        checkOutput("div_out_idle", div_out, 0);
      end
      if (cfg_err) begin
        checkOutput("cfg_err_expected", (err_seen < err_expected) ? 1 : 0, 1);
        err_seen++;
      end
      phase++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstn      = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    #1 rstn = 1'b0;
    #2 check_reset_values("reset");
    @(negedge clk);
    #2 rstn = 1'b1;

    $display("[TB] default ratio 4");
    repeat (3) exp_q.push_back(4);
    applyStimulus(1'b1, 1'b0, '0);
    wait_ticks(3);
    applyStimulus(1'b0, 1'b0, '0);
    idle_wait(8);

    $display("[TB] ratio 5 loaded in IDLE");
    offer(5, hold);
    checkOutput("idle_load_cur_div", cur_div, 5);
    checkOutput("idle_load_busy", busy, 0);
    checkOutput("idle_load_hold", hold, 0);
    repeat (3) exp_q.push_back(5);
    applyStimulus(1'b1, 1'b0, '0);
    wait_ticks(3);
    applyStimulus(1'b0, 1'b0, '0);
    idle_wait(8);

    $display("[TB] reprogram 8 -> 3 -> 6 while running");
    offer(8, hold);
    exp_q.push_back(8);
    exp_q.push_back(3);
    exp_q.push_back(6);
    applyStimulus(1'b1, 1'b0, '0);
    wait_ticks(1);
    offer(3, hold);
    checkOutput("pend_busy", busy, 1);
    checkOutput("pend_cfg_ready", cfg_ready, 0);
    checkOutput("pend_cur_div", cur_div, 8);
    offer(6, hold);
    checkOutput("second_offer_hold", hold, 5);
    checkOutput("second_offer_busy", busy, 1);
    wait_ticks(1);
    applyStimulus(1'b0, 1'b0, '0);
    idle_wait(10);

    $display("[TB] rejected ratio");
    err_expected++;
    offer(1, hold);
    checkOutput("reject_cur_div", cur_div, 6);
    checkOutput("reject_busy", busy, 0);
    idle_wait(2);

    $display("[TB] offer on the wrap edge");
    exp_q.push_back(6);
    exp_q.push_back(4);
    applyStimulus(1'b1, 1'b0, '0);
    wait_ticks(1);
    repeat (4) applyStimulus(1'b1, 1'b0, '0);
    offer(4, hold);
    checkOutput("wrap_offer_busy", busy, 0);
    checkOutput("wrap_offer_cur_div", cur_div, 4);
    applyStimulus(1'b0, 1'b0, '0);
    idle_wait(6);

    $display("[TB] graceful stop at counter 1 of ratio 6");
    offer(6, hold);
    exp_q.push_back(6);
    applyStimulus(1'b1, 1'b0, '0);
    wait_ticks(1);
    applyStimulus(1'b0, 1'b0, '0);
    idle_wait(8);

    $display("[TB] stop cancelled before the wrap");
    exp_q.push_back(6);
    exp_q.push_back(6);
    applyStimulus(1'b1, 1'b0, '0);
    wait_ticks(1);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);
    wait_ticks(1);
    applyStimulus(1'b0, 1'b0, '0);
    idle_wait(8);

    $display("[TB] reset mid-period with a ratio pending");
    exp_q.push_back(6);
    applyStimulus(1'b1, 1'b0, '0);
    wait_ticks(1);
    offer(3, hold);
    checkOutput("pre_reset_busy", busy, 1);
    #2 rstn = 1'b0;
    #1 check_reset_values("async_reset");
    en = 1'b0;
    @(negedge clk);
    #2 rstn = 1'b1;
    exp_q.push_back(4);
    exp_q.push_back(4);
    applyStimulus(1'b1, 1'b0, '0);
    wait_ticks(2);
    applyStimulus(1'b0, 1'b0, '0);
    idle_wait(6);

    checkOutput("periods_left", exp_q.size(), 0);
    checkOutput("cfg_err_count", err_seen, err_expected);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/divclk_ctrl.md
# divclk_ctrl

Run-time programmable clock-divider controller: derives a divided square wave and a one-cycle period tick from the system clock. Software or a CSR master reprograms the divide ratio through a valid/ready handshake. A new ratio is only applied at a period boundary, so `div_out` never shows a runt pulse. Start and stop are also graceful. The block sits between the CSR/peripheral bus and timer-driven peripherals (UART baud, LED scan, PWM) that need a reconfigurable rate while running.

## Interface
- `W`, 31: counter and ratio width.
- `N_DEFAULT`, 488: divide ratio loaded at reset; must satisfy 2 ≤ `N_DEFAULT` < 2^W.
- `clk`  in  1: system clock; all logic is on its rising edge.
- `rstn`  in  1: reset; asynchronous, active-low.
- `en`  in  1: run request (level).
- `cfg_valid`  in  1: new ratio offered.
- `cfg_div`  in  W: offered ratio.
- `cfg_ready`  out  1: ratio can be accepted; equals `!pend`.
- `cfg_err`  out  1: one-cycle pulse when an offered ratio is rejected.
- `busy`  out  1: an accepted ratio is waiting for a boundary (`pend`).
- `cur_div`  out  W: ratio currently in force.
- `tick`  out  1: one-cycle pulse on the first cycle of every period.
- `div_out`  out  1: divided wave.

## Operation
- States are IDLE, RUN and STOP. The pending flag `pend` and the register `nxt_div` are orthogonal to the state.
- Reset values:
  - State IDLE, counter 0, `cur_div` = `N_DEFAULT`, `pend` = 0.
  - Outputs: `tick` = 0, `div_out` = 0, `cfg_err` = 0, `busy` = 0, `cfg_ready` = 1.
- Handshake: a transfer occurs on an edge where `cfg_valid && cfg_ready`.
  - `cfg_div` < 2 is rejected: `cfg_err` pulses on the next cycle and the block state is unchanged. The transfer still counts as accepted, so the master must not hold the offer.
- IDLE:
  - `div_out` = 0 and `tick` = 0.
  - A valid transfer loads `cur_div` directly; `pend` stays 0.
  - `en` = 1 moves to RUN with counter 0.
- RUN:
  - The counter counts 0..`cur_div`−1 and then wraps.
  - `div_out` = 1 while counter < `cur_div`>>1, else 0. An odd ratio therefore gives a high phase of floor(N/2) and a low phase of ceil(N/2).
  - `tick` = 1 when counter = 0.
  - A valid transfer stores the ratio in `nxt_div` and sets `pend`.
  - At a wrap, if `pend` is set: `cur_div` ← `nxt_div`, `pend` cleared, and the new period uses the new ratio.
  - A transfer on the same edge as a wrap is applied at that wrap, with no extra period of delay.
  - `en` = 0 moves to STOP.
- STOP:
  - Finishes the current period; the counter keeps running.
  - At the wrap: go to IDLE, apply any pending ratio, and drive `div_out` = 0 and `tick` = 0.
  - `en` = 1 re-seen before the wrap returns to RUN with no discontinuity.
- Reset asserted mid-operation: immediate return to all reset values. Any pending ratio is lost.

## Timing
- Outputs `tick`, `div_out` and `cfg_err` are registered, with no combinational path from inputs. `cfg_ready` and `busy` are decoded from the `pend` register.
- Start: `en` sampled high at edge k in IDLE → `tick` = 1 and `div_out` = 1 during cycle k+1.
- Steady state: `tick` period is exactly `cur_div` cycles. `div_out` rises in the same cycle as `tick`.
- Reconfiguration latency: from acceptance to the new period is between 1 and `cur_div` cycles.
- `cur_div` updates in the same cycle as the first `tick` of the new period.
- Stop: `div_out` is 0 from the cycle after the last counter value `cur_div`−1.
- Counter width is W. The comparison for the high phase uses `cur_div`>>1 and never overflows.

## Structure
- Package `divclk_pkg`:
  - the state enum `{IDLE, RUN, STOP}`;
  - `DIV_MIN` = 2;
  - the default W.
- One sub-module, `div_counter`: a W-bit counter with `clr`, an enable, the terminal count `cur_div`−1 and a `wrap` output. It generates `wrap` and `cnt`. The FSM, handshake and output registers stay in `divclk_ctrl`.

## Test plan
- Reset with `N_DEFAULT` = 4; raise `en` → `tick` every 4 cycles; `div_out` pattern 1,1,0,0; `cur_div` = 4.
- Ratio 5 accepted in IDLE, then `en` → `div_out` pattern 1,1,0,0,0 repeating; `tick` period 5.
- Running at ratio 8, offer 3 mid-period → `busy` = 1 and `cfg_ready` = 0 until the wrap. Next period is 3 cycles with pattern 1,0,0. A second offer is held off and accepted once `cfg_ready` returns to 1.
- Offer ratio 1 → `cfg_err` pulses once; `cur_div` and `pend` are unchanged.
- Offer on the exact wrap edge (counter = `cur_div`−1) → the new ratio applies to the immediately following period.
- Drop `en` at counter 1 of ratio 6 → 4 more cycles of the old pattern, then IDLE with `div_out` = 0. Assert `rstn` = 0 mid-period → all outputs reset asynchronously and `cur_div` = `N_DEFAULT`.
